// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: front end for a UART receiver core.
// - Synchronizes the serial line (two flops) and hands it to the receiver.
// - Generates the oversample tick from the system clock.
// - Buffers received bytes in a small FIFO with a sticky overflow flag.
// Optional feature: define UART_RX_CTRL_ERRCNT_EN to add the saturating
// errCount output that counts receiver error ticks.
module uart_rx_ctrl #(
  parameter int Oversample = 16,
  parameter int Divisor    = 27,
  parameter int FifoDepth  = 4
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       rxPin,
  input  logic       enable,
  output logic       rxEn,
  output logic       rxIn,
  input  logic [7:0] rxData,
  input  logic       rxDone,
  input  logic       rxErr,
  output logic [7:0] outData,
  output logic       outValid,
  input  logic       outReady,
  output logic       overflow,
  input  logic       clearOverflow
`ifdef UART_RX_CTRL_ERRCNT_EN
  ,
  output logic [7:0] errCount
`endif
);

  localparam int TcW  = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam logic [TcW-1:0]  TcReload = TcW'(Divisor - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FifoDepth);
  // An out-of-range configuration never produces ticks, so it cannot
  // silently run at a wrong bit rate.
  localparam bit CfgOk = (Oversample >= 4) && (Divisor >= 1) && (FifoDepth >= 2);

  // Line synchronizer
  logic sync_1;

  // Tick generator
  logic [TcW-1:0] tc;
  logic [TcW-1:0] tc_next;
  logic           rx_en_next;

  // FIFO storage and control
  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [PtrW-1:0] wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_next;
  logic [CntW-1:0] count_next;
  logic [7:0]      head_next;
  logic            push_req;
  logic            push_acc;
  logic            pop;
  logic            full;
  logic            drop;
  logic            overflow_next;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_1 <= 1'b1;
      rxIn   <= 1'b1;
    end else begin
      sync_1 <= rxPin;
      rxIn   <= sync_1;
    end
  end

  // Tick counter next state: count down while enabled, pulse and reload at zero.
  always_comb begin
    tc_next    = tc;
    rx_en_next = 1'b0;
    if (enable && CfgOk) begin
      if (tc == {TcW{1'b0}}) begin
        tc_next    = TcReload;
        rx_en_next = 1'b1;
      end else begin
        tc_next = tc - TcW'(1);
      end
    end else begin
      tc_next = TcReload;
    end
  end

  // Tick counter and registered oversample tick.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tc   <= TcReload;
      rxEn <= 1'b0;
    end else begin
      tc   <= tc_next;
      rxEn <= rx_en_next;
    end
  end

  // FIFO next state: accept/drop decision, pointer and count updates, new head.
  always_comb begin
    push_req = rxDone & rxEn & ~rxErr;
    pop      = outValid & outReady;
    full     = (count == CntFull);
    push_acc = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    wr_ptr_next = wr_ptr;
    if (push_acc) begin
      wr_ptr_next = wr_ptr + PtrW'(1);
    end else begin
      wr_ptr_next = wr_ptr;
    end

    rd_ptr_next = rd_ptr;
    if (pop) begin
      rd_ptr_next = rd_ptr + PtrW'(1);
    end else begin
      rd_ptr_next = rd_ptr;
    end

    count_next = count;
    case ({push_acc, pop})
      2'b10:   count_next = count + CntW'(1);
      2'b01:   count_next = count - CntW'(1);
      default: count_next = count;
    endcase

    // The byte being written becomes the head when it lands on the new read slot.
    head_next = mem[rd_ptr_next];
    if (push_acc && (wr_ptr == rd_ptr_next)) begin
      head_next = rxData;
    end else begin
      head_next = mem[rd_ptr_next];
    end

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_next = overflow;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clearOverflow) begin
      overflow_next = 1'b0;
    end else begin
      overflow_next = overflow;
    end
  end

  // FIFO state registers and registered head/valid/overflow outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr   <= {PtrW{1'b0}};
      rd_ptr   <= {PtrW{1'b0}};
      count    <= {CntW{1'b0}};
      outData  <= 8'h00;
      outValid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= rxData;
      end
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      outData  <= head_next;
      outValid <= (count_next != {CntW{1'b0}});
      overflow <= overflow_next;
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  // Saturating count of receiver errors reported on a tick; cleared only by reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      errCount <= 8'h00;
    end else if (rxErr && rxEn && (errCount != 8'hFF)) begin
      errCount <= errCount + 8'h01;
    end else begin
      errCount <= errCount;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (Divisor=4, FifoDepth=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       nReset;
  logic       rxPin;
  logic       enable;
  logic       rxEn;
  logic       rxIn;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       overflow;
  logic       clearOverflow;
`ifdef UART_RX_CTRL_ERRCNT_EN
  logic [7:0] errCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_ctrl #(
    .Oversample(16),
    .Divisor(4),
    .FifoDepth(4)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .rxPin(rxPin),
    .enable(enable),
    .rxEn(rxEn),
    .rxIn(rxIn),
    .rxData(rxData),
    .rxDone(rxDone),
    .rxErr(rxErr),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .overflow(overflow),
    .clearOverflow(clearOverflow)
`ifdef UART_RX_CTRL_ERRCNT_EN
    ,
    .errCount(errCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a tick, then present a receiver completion on that tick.
  task automatic push_byte(input logic [7:0] b, input logic err, input logic pop,
                           input logic clr);
    int n;
    n = 0;
    while (!rxEn && n < 16) begin
      step();
      n++;
    end
    if (!rxEn) check_eq("tick_timeout", {31'd0, rxEn}, 32'd1);
    rxData        = b;
    rxDone        = 1'b1;
    rxErr         = err;
    outReady      = pop;
    clearOverflow = clr;
    step();
    rxDone        = 1'b0;
    rxErr         = 1'b0;
    outReady      = 1'b0;
    clearOverflow = 1'b0;
  endtask

  initial begin
    nReset        = 1'b0;
    rxPin         = 1'b1;
    enable        = 1'b0;
    rxData        = 8'h00;
    rxDone        = 1'b0;
    rxErr         = 1'b0;
    outReady      = 1'b0;
    clearOverflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check_eq("rst_rxEn", {31'd0, rxEn}, 32'd0);
    check_eq("rst_rxIn", {31'd0, rxIn}, 32'd1);
    check_eq("rst_outValid", {31'd0, outValid}, 32'd0);
    check_eq("rst_outData", {24'd0, outData}, 32'h00);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    nReset = 1'b1;
    step();

    // Tick timing: enable at cycle 0 -> pulses at 4, 8, 12; off from cycle 13
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_eq($sformatf("tick_%0d", k), {31'd0, rxEn},
               {31'd0, (k == 4 || k == 8 || k == 12)});
      if (k == 13) enable = 1'b0;
    end
    // Counter held at reload: re-enable gives the first tick 4 cycles later
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq($sformatf("reen_tick_%0d", k), {31'd0, rxEn}, {31'd0, (k == 4)});
    end

    // Synchronizer latency: two cycles
    rxPin = 1'b0;
    step();
    check_eq("rxIn_lat1", {31'd0, rxIn}, 32'd1);
    step();
    check_eq("rxIn_lat2", {31'd0, rxIn}, 32'd0);
    rxPin = 1'b1;

    // Single byte push and pop
    push_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("a5_valid", {31'd0, outValid}, 32'd1);
    check_eq("a5_data", {24'd0, outData}, 32'hA5);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    check_eq("a5_popped", {31'd0, outValid}, 32'd0);

    // rxDone without a tick is ignored (tick is low right after a pulse)
    check_eq("notick_rxEn", {31'd0, rxEn}, 32'd0);
    rxData = 8'h77;
    rxDone = 1'b1;
    step();
    rxDone = 1'b0;
    check_eq("notick_nopush", {31'd0, outValid}, 32'd0);

    // rxErr blocks the push even with rxDone and a tick
    push_byte(8'h99, 1'b1, 1'b0, 1'b0);
    check_eq("err_nopush", {31'd0, outValid}, 32'd0);

    // Five pushes into four entries: last one dropped
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b0);
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("ovf_valid_%0d", i), {31'd0, outValid}, 32'd1);
      check_eq($sformatf("ovf_pop_%0d", i), {24'd0, outData}, i);
      step();
    end
    outReady = 1'b0;
    check_eq("ovf_empty", {31'd0, outValid}, 32'd0);
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    check_eq("ovf_clear", {31'd0, overflow}, 32'd0);

    // Fill, then a drop coinciding with clearOverflow keeps the flag set
    push_byte(8'h11, 1'b0, 1'b0, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0, 1'b0, 1'b0);
    push_byte(8'h44, 1'b0, 1'b0, 1'b0);
    push_byte(8'h66, 1'b0, 1'b0, 1'b1);
    check_eq("drop_wins", {31'd0, overflow}, 32'd1);
    check_eq("drop_head", {24'd0, outData}, 32'h11);
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    check_eq("drop_clear", {31'd0, overflow}, 32'd0);

    // Push with simultaneous pop while full: both accepted, no overflow
    push_byte(8'h55, 1'b0, 1'b1, 1'b0);
    check_eq("full_pp_ovf", {31'd0, overflow}, 32'd0);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      case (i)
        0:       exp_b = 8'h22;
        1:       exp_b = 8'h33;
        2:       exp_b = 8'h44;
        default: exp_b = 8'h55;
      endcase
      check_eq($sformatf("full_pp_pop_%0d", i), {24'd0, outData}, {24'd0, exp_b});
      step();
    end
    outReady = 1'b0;
    check_eq("full_pp_empty", {31'd0, outValid}, 32'd0);

    // Push with pop request while empty: only the push happens
    push_byte(8'h3C, 1'b0, 1'b1, 1'b0);
    check_eq("empty_pp_valid", {31'd0, outValid}, 32'd1);
    check_eq("empty_pp_data", {24'd0, outData}, 32'h3C);
    step();
    check_eq("empty_pp_hold", {31'd0, outValid}, 32'd1);

    // Asynchronous reset mid-stream discards buffered bytes
    nReset = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, outValid}, 32'd0);
    check_eq("mid_rst_data", {24'd0, outData}, 32'h00);
    check_eq("mid_rst_rxEn", {31'd0, rxEn}, 32'd0);
    nReset = 1'b1;
    step();
    check_eq("post_rst_valid", {31'd0, outValid}, 32'd0);

`ifdef UART_RX_CTRL_ERRCNT_EN
    // Error counter: three ticked errors, one unticked, none pushed
    check_eq("ec_reset", {24'd0, errCount}, 32'd0);
    push_byte(8'h01, 1'b1, 1'b0, 1'b0);
    push_byte(8'h02, 1'b1, 1'b0, 1'b0);
    push_byte(8'h03, 1'b1, 1'b0, 1'b0);
    check_eq("ec_notick_rxEn", {31'd0, rxEn}, 32'd0);
    rxErr  = 1'b1;
    rxDone = 1'b1;
    step();
    rxErr  = 1'b0;
    rxDone = 1'b0;
    check_eq("ec_three", {24'd0, errCount}, 32'd3);
    check_eq("ec_nopush", {31'd0, outValid}, 32'd0);
    // 300 more ticked errors saturate at 255
    rxErr = 1'b1;
    repeat (1210) step();
    rxErr = 1'b0;
    check_eq("ec_sat", {24'd0, errCount}, 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter Oversample, default 16, receiver oversample ratio (ticks per bit); informational for tick rate, min 4.
REQ-002 SHALL have parameter Divisor, default 27, clk cycles per oversample tick, min 1.
REQ-003 SHALL have parameter FifoDepth, default 4, received-byte FIFO entries, power of two, min 2.
REQ-004 SHALL have ports: clk in 1 system clock; nReset in 1 reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: rxPin in 1 asynchronous serial line, idle high; enable in 1 software receive enable.
REQ-006 SHALL have ports: rxEn out 1 oversample tick to receiver; rxIn out 1 synchronized line to receiver.
REQ-007 SHALL have ports: rxData in 8, rxDone in 1, rxErr in 1, from receiver.
REQ-008 SHALL have ports: outData out 8 FIFO head; outValid out 1 FIFO non-empty; outReady in 1 consumer accept.
REQ-009 SHALL have ports: overflow out 1 sticky drop flag; clearOverflow in 1 clears it; errCount out 8, present only with macro (REQ-024).

Function
REQ-010 SHALL synchronize rxPin through a 2-flop chain; rxIn = second flop; rxPin-to-rxIn latency 2 cycles.
REQ-011 SHALL run tick counter tc: while enable=1, tc decrements each cycle; at tc==0, rxEn=1 for that cycle and tc reloads Divisor-1.
REQ-012 SHALL hold tc at Divisor-1 with rxEn=0 while enable=0; first tick after enable rises occurs Divisor cycles later. Divisor=1 gives rxEn=enable.
REQ-013 SHALL push rxData into FIFO in a cycle where rxDone=1, rxEn=1 and rxErr=0; rxDone without rxEn SHALL be ignored.
REQ-014 SHALL never push when rxErr=1, even if rxDone=1 that cycle.
REQ-015 SHALL present outValid = (count != 0), outData = head entry, both registered; pushed byte visible on outValid the cycle after push.
REQ-016 SHALL pop when outValid=1 and outReady=1; outReady with empty FIFO is a no-op.
REQ-017 SHALL, on push with FIFO full and no pop, drop the byte, leave contents unchanged, set overflow.
REQ-018 SHALL, on push and pop in the same cycle while full, accept both; count unchanged, overflow not set.
REQ-019 SHALL, on push and pop in the same cycle while empty, perform only the push (pop ignored, outValid was 0).
REQ-020 SHALL clear overflow when clearOverflow=1; a new drop in the same cycle wins (overflow stays 1).
REQ-021 SHALL wrap read/write pointers modulo FifoDepth; count width $clog2(FifoDepth)+1.
REQ-022 SHALL retain FIFO contents and overflow when enable falls mid-frame; only ticks stop.

Reset
REQ-023 SHALL, on nReset low, asynchronously set: sync flops 1, rxIn 1, tc Divisor-1, rxEn 0, pointers and count 0, outValid 0, outData 0, overflow 0, errCount 0; reset mid-frame discards all buffered bytes.

Configuration
REQ-024 SHALL, with UART_RX_CTRL_ERRCNT_EN defined, provide errCount: increments by 1 in each cycle with rxErr=1 and rxEn=1, saturates at 255, cleared only by reset.
REQ-025 SHALL, without UART_RX_CTRL_ERRCNT_EN, omit errCount port and its logic; all other behaviour identical.

Verification (Divisor=4, Oversample=16, FifoDepth=4)
REQ-026 SHALL check enable rises at cycle 0 -> rxEn pulses at cycles 4, 8, 12, one cycle wide; enable low at cycle 13 -> no further pulses, tc=3.
REQ-027 SHALL check rxPin drop at cycle 10 -> rxIn low at cycle 12.
REQ-028 SHALL check rxDone with rxEn, rxData=0xA5, outReady=0 -> outValid=1, outData=0xA5 next cycle; outReady=1 -> outValid=0 next cycle.
REQ-029 SHALL check 5 pushes 0x01..0x05, outReady=0 -> overflow=1, pops return 0x01..0x04 then outValid=0; clearOverflow -> overflow=0.
REQ-030 SHALL check full FIFO, push 0x55 with simultaneous pop -> no overflow, fourth pop returns 0x55.
REQ-031 SHALL check (macro on) 3 cycles rxErr with rxEn, plus rxErr without rxEn, rxDone=1 -> errCount=3, no push; 300 errors -> errCount=255.
